// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin two-requester arbiter with bus lock in front of a single-ported LSU.
// Grant statistics counters are built only when LSU_ARB_STATS_EN is defined.
module lsu_arbiter #(
  parameter int unsigned MAX_LOCK = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic             m0_lock,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic             m1_lock,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             o_lsu_we,
  output logic             o_lsu_re,
  output logic [31:0]      o_lsu_addr,
  output logic [31:0]      o_lsu_wdata,
  input  logic [31:0]      i_lsu_rdata,
  output logic [CNT_W-1:0] o_grant_cnt0,
  output logic [CNT_W-1:0] o_grant_cnt1
);

  typedef enum logic [1:0] {StUnlocked, StLocked0, StLocked1} lock_state_e;

  lock_state_e state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        blk_vld_q, blk_vld_d;
  logic        blk_id_q, blk_id_d;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        gnt0, gnt1, req0_eff, req1_eff;
  logic        owner, owner_lock;

  always_comb begin
    // After a forced release the old owner may not re-lock while the other side waits.
    req0_eff = m0_req & ~(blk_vld_q & ~blk_id_q & m1_req & m0_lock);
    req1_eff = m1_req & ~(blk_vld_q & blk_id_q & m0_req & m1_lock);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      StLocked0: gnt0 = m0_req;
      StLocked1: gnt1 = m1_req;
      default: begin
        if (req0_eff && req1_eff) begin
          gnt0 = last_gnt_q;
          gnt1 = ~last_gnt_q;
        end else begin
          gnt0 = req0_eff;
          gnt1 = req1_eff;
        end
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    blk_vld_d  = blk_vld_q;
    blk_id_d   = blk_id_q;
    owner      = (state_q == StLocked1);
    owner_lock = owner ? m1_lock : m0_lock;
    if (gnt0) begin
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
    end
    if (blk_vld_q && !(blk_id_q ? m0_req : m1_req)) begin
      blk_vld_d = 1'b0;
    end
    case (state_q)
      StLocked0, StLocked1: begin
        if (!owner_lock) begin
          state_d    = StUnlocked;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == 8'(MAX_LOCK - 1)) begin
          state_d    = StUnlocked;
          lock_cnt_d = '0;
          last_gnt_d = owner;
          blk_vld_d  = 1'b1;
          blk_id_d   = owner;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = StUnlocked;
        lock_cnt_d = '0;
        if (gnt0 && m0_lock) begin
          state_d = StLocked0;
        end else if (gnt1 && m1_lock) begin
          state_d = StLocked1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StUnlocked;
      lock_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      blk_vld_q  <= 1'b0;
      blk_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_gnt_q <= last_gnt_d;
      blk_vld_q  <= blk_vld_d;
      blk_id_q   <= blk_id_d;
    end
  end

  always_comb begin
    o_lsu_we    = 1'b0;
    o_lsu_re    = 1'b0;
    o_lsu_addr  = '0;
    o_lsu_wdata = '0;
    if (gnt0) begin
      o_lsu_we    = m0_we;
      o_lsu_re    = ~m0_we;
      o_lsu_addr  = m0_addr & ~32'h3;
      o_lsu_wdata = m0_wdata;
    end else if (gnt1) begin
      o_lsu_we    = m1_we;
      o_lsu_re    = ~m1_we;
      o_lsu_addr  = m1_addr & ~32'h3;
      o_lsu_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~m0_we;
      rvalid1_q <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) rdata0_q <= i_lsu_rdata;
      if (gnt1 && !m1_we) rdata1_q <= i_lsu_rdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

`ifdef LSU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + 1'b1;
      if (gnt1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign o_grant_cnt0 = cnt0_q;
  assign o_grant_cnt1 = cnt1_q;
`else
  assign o_grant_cnt0 = '0;
  assign o_grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: default instance plus a MAX_LOCK=4 instance for forced release.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] i_lsu_rdata;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        o_lsu_we, o_lsu_re;
  logic [31:0] o_lsu_addr, o_lsu_wdata;
  logic [15:0] o_grant_cnt0, o_grant_cnt1;

  logic        d4_m0_gnt, d4_m0_rvalid, d4_m1_gnt, d4_m1_rvalid;
  logic [31:0] d4_m0_rdata, d4_m1_rdata;
  logic        d4_lsu_we, d4_lsu_re;
  logic [31:0] d4_lsu_addr, d4_lsu_wdata;
  logic [15:0] d4_cnt0, d4_cnt1;

  logic [31:0] mem [64];
  int          n_vec = 0;
  int          n_err = 0;

`ifdef LSU_ARB_STATS_EN
  localparam logic [31:0] ExpCnt0 = 32'd5;
  localparam logic [31:0] ExpCnt1 = 32'd3;
`else
  localparam logic [31:0] ExpCnt0 = 32'd0;
  localparam logic [31:0] ExpCnt1 = 32'd0;
`endif

  always #5 clk = ~clk;

  lsu_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .o_lsu_we(o_lsu_we), .o_lsu_re(o_lsu_re), .o_lsu_addr(o_lsu_addr),
    .o_lsu_wdata(o_lsu_wdata), .i_lsu_rdata(i_lsu_rdata),
    .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1)
  );

  lsu_arbiter #(.MAX_LOCK(4)) dut4 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(d4_m0_gnt), .m0_rvalid(d4_m0_rvalid), .m0_rdata(d4_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(d4_m1_gnt), .m1_rvalid(d4_m1_rvalid), .m1_rdata(d4_m1_rdata),
    .o_lsu_we(d4_lsu_we), .o_lsu_re(d4_lsu_re), .o_lsu_addr(d4_lsu_addr),
    .o_lsu_wdata(d4_lsu_wdata), .i_lsu_rdata(i_lsu_rdata),
    .o_grant_cnt0(d4_cnt0), .o_grant_cnt1(d4_cnt1)
  );

  // Small word memory standing in for the LSU, driven by the default instance.
  always @(posedge clk) begin
    if (o_lsu_we) mem[o_lsu_addr[7:2]] <= o_lsu_wdata;
  end
  assign i_lsu_rdata = mem[o_lsu_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m0_req = 1'b1;
    #2;
    check("rst m0_gnt", m0_gnt, 0);
    check("rst m1_gnt", m1_gnt, 0);
    check("rst lsu_we", o_lsu_we, 0);
    check("rst lsu_re", o_lsu_re, 0);
    check("rst m0_rvalid", m0_rvalid, 0);
    check("rst m1_rdata", m1_rdata, 0);
    check("rst cnt0", o_grant_cnt0, 0);
    m0_req = 1'b0;
    tick();
    rst = 1'b0;

    // Both store continuously: grants alternate starting with m0.
    for (int i = 0; i < 4; i++) begin
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA000_0000 + i;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hB000_0000 + i;
      #1;
      check("rr m0_gnt", m0_gnt, (i % 2 == 0));
      check("rr m1_gnt", m1_gnt, (i % 2 == 1));
      check("rr lsu_we", o_lsu_we, 1);
      check("rr lsu_wdata", o_lsu_wdata,
            (i % 2 == 0) ? 32'hA000_0000 + i : 32'hB000_0000 + i);
      tick();
    end

    // m0 stores, m1 loads from an unaligned address in the same word.
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2004; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("st m0_gnt", m0_gnt, 1);
    check("st lsu_addr", o_lsu_addr, 32'h2004);
    tick();
    idle_inputs();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2006;
    #1;
    check("ld m1_gnt", m1_gnt, 1);
    check("ld lsu_addr", o_lsu_addr, 32'h2004);
    check("ld lsu_re", o_lsu_re, 1);
    check("ld lsu_we", o_lsu_we, 0);
    tick();
    idle_inputs();
    #1;
    check("ld m1_rvalid", m1_rvalid, 1);
    check("ld m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("ld m0_rvalid", m0_rvalid, 0);
    tick();
    check("ld m1_rvalid drop", m1_rvalid, 0);
    check("ld m1_rdata hold", m1_rdata, 32'hDEAD_BEEF);

    // m0 holds the lock for 4 cycles; m1 stalls, including the idle-owner cycle.
    for (int i = 0; i < 4; i++) begin
      m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h30; m0_wdata = i;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h34; m1_wdata = 32'h55;
      #1;
      check("lk m0_gnt", m0_gnt, 1);
      check("lk m1_gnt", m1_gnt, 0);
      tick();
    end
    m0_req = 1'b0; m0_lock = 1'b0;
    #1;
    check("lk idle owner m1_gnt", m1_gnt, 0);
    tick();
    check("lk release m1_gnt", m1_gnt, 1);
    tick();

    // Forced release with MAX_LOCK=4.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44;
    #1;
    check("fr take m0_gnt", d4_m0_gnt, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("fr locked m0_gnt", d4_m0_gnt, 1);
      check("fr locked m1_gnt", d4_m1_gnt, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check("fr after m1_gnt", d4_m1_gnt, 1);
      check("fr after m0_gnt", d4_m0_gnt, 0);
      tick();
    end
    m1_req = 1'b0;
    #1;
    check("fr relock m0_gnt", d4_m0_gnt, 1);
    tick();

    // Asynchronous reset mid-cycle during a granted load.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2004;
    #1;
    check("ar m0_gnt", m0_gnt, 1);
    tick();
    check("ar m0_rvalid", m0_rvalid, 1);
    check("ar m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check("ar gnt fall", m0_gnt, 0);
    check("ar rvalid fall", m0_rvalid, 0);
    check("ar rdata clr", m0_rdata, 0);
    check("ar lsu_re", o_lsu_re, 0);
    m0_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("ar no rvalid", m0_rvalid, 0);

    // 5 grants to m0 and 3 to m1.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h50;
    tick();
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h54;
    for (int i = 0; i < 6; i++) tick();
    idle_inputs();
    tick();
    check("stats cnt0", o_grant_cnt0, ExpCnt0);
    check("stats cnt1", o_grant_cnt1, ExpCnt1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
